// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample majority vote, optional parity, 1 or 2 stop bits.
// Defining UART_RX_BREAK_DET_EN adds the brk_det output and a BREAK wait state.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                  brk_det
`endif
);

    localparam int unsigned PW    = PRESCALE_W;
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_DET_EN
        ,
        S_BREAK
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   edge_q, edge_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [2:0]      smp_q, smp_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            par_en_q, par_en_d;
    logic            par_typ_q, par_typ_d;
    logic            stp2_q, stp2_d;
    logic            par_bad_q, par_bad_d;
    logic            stp_bad_q, stp_bad_d;
    logic            armed_q, armed_d;
    logic [DW-1:0]   p_data_q, p_data_d;
    logic            dv_q, dv_d;
    logic            pe_q, pe_d;
    logic            se_q, se_d;
`ifdef UART_RX_BREAK_DET_EN
    logic            zero_q, zero_d;
    logic            brk_q, brk_d;
`endif

    logic [PW-1:0]   half_c;
    logic            vote_c, vote_edge_c, bit_end_c, stp_fail_c;

    assign half_c      = presc_q >> 1;
    assign vote_c      = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign vote_edge_c = (edge_q == half_c + PW'(2));
    assign bit_end_c   = (edge_q == presc_q - PW'(1));
    assign stp_fail_c  = stp_bad_q | ~vote_c;

    // Next-state, counters, sampling and registered output pulses
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        smp_d     = smp_q;
        shreg_d   = shreg_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stp2_d    = stp2_q;
        par_bad_d = par_bad_q;
        stp_bad_d = stp_bad_q;
        armed_d   = armed_q | RX_IN;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        zero_d    = zero_q;
        brk_d     = 1'b0;
`endif

        if (state_q != S_IDLE) begin
            if (edge_q == half_c - PW'(1)) smp_d[0] = RX_IN;
            if (edge_q == half_c)          smp_d[1] = RX_IN;
            if (edge_q == half_c + PW'(1)) smp_d[2] = RX_IN;
            edge_d = bit_end_c ? '0 : edge_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                // A start edge only counts once the line has been seen idle
                if (armed_q && !RX_IN) begin
                    state_d   = S_START;
                    presc_d   = Prescale;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stp2_d    = STP2;
                    par_bad_d = 1'b0;
                    stp_bad_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d    = 1'b1;
`endif
                end
            end
            S_START: begin
                if (vote_edge_c && vote_c) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                end else if (bit_end_c) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (vote_edge_c) begin
                    shreg_d = {vote_c, shreg_q[DW-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                    zero_d  = zero_q & ~vote_c;
`endif
                end
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(DW - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (vote_edge_c) begin
                    par_bad_d = vote_c ^ (^shreg_q) ^ par_typ_q;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d    = zero_q & ~vote_c;
`endif
                end
                if (bit_end_c) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (vote_edge_c && stp2_q && (bit_q == '0)) begin
                    stp_bad_d = stp_fail_c;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d    = zero_q & ~vote_c;
`endif
                end else if (vote_edge_c) begin
                    // Last stop bit: report now and re-arm without waiting for the bit to end
                    state_d = S_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
`ifdef UART_RX_BREAK_DET_EN
                    if (zero_q && !vote_c) begin
                        brk_d   = 1'b1;
                        state_d = S_BREAK;
                    end else
`endif
                    begin
                        pe_d = par_bad_q;
                        se_d = stp_fail_c;
                        if (!par_bad_q && !stp_fail_c) begin
                            dv_d     = 1'b1;
                            p_data_d = shreg_q;
                        end
                    end
                end
                if (bit_end_c && !vote_edge_c) bit_d = bit_q + BIT_W'(1);
            end
`ifdef UART_RX_BREAK_DET_EN
            S_BREAK: begin
                edge_d = '0;
                if (RX_IN) state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            smp_q     <= '0;
            shreg_q   <= '0;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stp2_q    <= 1'b0;
            par_bad_q <= 1'b0;
            stp_bad_q <= 1'b0;
            armed_q   <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_q    <= 1'b0;
            brk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            smp_q     <= smp_d;
            shreg_q   <= shreg_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stp2_q    <= stp2_d;
            par_bad_q <= par_bad_d;
            stp_bad_q <= stp_bad_d;
            armed_q   <= armed_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
`ifdef UART_RX_BREAK_DET_EN
            zero_q    <= zero_d;
            brk_q     <= brk_d;
`endif
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;
`ifdef UART_RX_BREAK_DET_EN
    assign brk_det    = brk_q;
`endif

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter PRESCALE_W, default 6: width of Prescale and of the internal edge counter.
REQ-003 SHALL have port CLK  input  1  single oversampling clock; all logic is on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX_IN  input  1  serial line; idles high; frames are sent LSB first.
REQ-006 SHALL have port Prescale  input  PRESCALE_W  CLK cycles per bit; even, and at least 8.
REQ-007 SHALL have port PAR_EN  input  1  1 means a parity bit follows the data.
REQ-008 SHALL have port PAR_TYP  input  1  0 selects even parity, 1 selects odd parity.
REQ-009 SHALL have port STP2  input  1  1 means two stop bits, 0 means one.
REQ-010 SHALL have port P_DATA  output  DATA_WIDTH  last good received word.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-012 SHALL have port par_err  output  1  one-cycle pulse on a parity mismatch.
REQ-013 SHALL have port stp_err  output  1  one-cycle pulse when a stop bit is sampled 0.

Function
REQ-014 SHALL latch Prescale, PAR_EN, PAR_TYP and STP2 when a start edge is detected; input changes mid-frame SHALL be ignored.
REQ-015 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-016 SHALL move from IDLE to START in the cycle after RX_IN is seen low; the edge counter restarts at 0 on that move.
REQ-017 SHALL count edges 0..Prescale-1 per bit, then wrap to 0 and advance the bit counter.
REQ-018 SHALL sample RX_IN at edges P/2-1, P/2 and P/2+1, and SHALL decide each bit by majority vote at edge P/2+2.
REQ-019 SHALL return from START to IDLE with no flags raised if the start bit is voted 1 (glitch).
REQ-020 SHALL shift the DATA_WIDTH data bits into a shift register LSB first.
REQ-021 SHALL use the PARITY state only when PAR_EN=1; the expected bit SHALL be XOR(data) for even parity and its inverse for odd.
REQ-022 SHALL use one STOP bit, or two when STP2=1; either stop bit voted 0 SHALL be a stop error.
REQ-023 SHALL enter IDLE in the cycle after the vote on the last stop bit, without waiting for the bit to end, so back-to-back frames resynchronise.
REQ-024 SHALL, on a frame with no error, load P_DATA and pulse data_valid for 1 cycle; this happens 1 cycle after the last stop-bit vote.
REQ-025 SHALL, on an errored frame, pulse par_err and/or stp_err in that same cycle; data_valid SHALL stay 0 and P_DATA SHALL stay unchanged.
REQ-026 SHALL hold P_DATA between frames; par_err, stp_err and data_valid SHALL never be high for more than 1 cycle.

Reset
REQ-027 SHALL, while RST=0, force the FSM to IDLE, clear both counters, set P_DATA to 0 and set data_valid, par_err and stp_err to 0, with no clock needed.
REQ-028 SHALL drop any frame in progress when reset is asserted mid-frame, and SHALL raise no flag for it.
REQ-029 SHALL, after reset is released, ignore RX_IN until it has been sampled high once (line-idle qualification).

Configuration
REQ-030 SHALL compile in line-break detection when UART_RX_BREAK_DET_EN is defined: a 1-bit output brk_det is added.
REQ-031 SHALL, with UART_RX_BREAK_DET_EN defined, treat a frame whose data, parity and stop bits all vote 0 as a break: brk_det pulses 1 cycle instead of stp_err, the FSM waits in a BREAK state until RX_IN is sampled 1, and then enters IDLE.
REQ-032 SHALL, without UART_RX_BREAK_DET_EN, omit the brk_det port and the BREAK state; an all-zero frame reports stp_err and re-arms IDLE at once.

Verification
REQ-033 SHALL cover: Prescale=8, PAR_EN=0, frame 0xA5 with 1 stop bit -> data_valid pulse, P_DATA=0xA5, no error flags.
REQ-034 SHALL cover: Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C sent with parity bit 1 -> par_err pulse, data_valid=0, P_DATA keeps its old value.
REQ-035 SHALL cover: STP2=1, second stop bit driven 0 -> stp_err pulse; the next frame 0x5A received back-to-back -> P_DATA=0x5A.
REQ-036 SHALL cover: a 2-cycle low glitch on RX_IN with Prescale=16 -> FSM returns to IDLE, no output activity.
REQ-037 SHALL cover: DATA_WIDTH=7, Prescale=32, a 1-cycle inverted spike at mid-bit on every bit of 0x55 -> majority vote rejects it, P_DATA=0x55.
REQ-038 SHALL cover: RST=0 asserted mid-DATA then released -> all outputs 0, the next frame 0x81 is received correctly; with UART_RX_BREAK_DET_EN defined, 12 low bit-times -> a single brk_det pulse and no stp_err.
